// File: rtl/rom24_pkg.sv
// Shared types and constants for the 24x8 ROM bank read arbiter.
package rom24_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

    localparam int ROM_DEPTH = 8;
    localparam int NUM_ROMS  = 3;
    localparam int ROM_AW    = 3;

endpackage

// File: rtl/rom24_addr_decode.sv
// Linear address -> one-hot ROM chip select, local ROM address and out-of-range flag.
module rom24_addr_decode
    import rom24_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_ROMS = rom24_pkg::NUM_ROMS,
    parameter int ROM_AW   = rom24_pkg::ROM_AW
) (
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_ROMS-1:0] cs,
    output logic [ROM_AW-1:0]   addrb,
    output logic                oor
);

    logic [ADDR_W-ROM_AW-1:0] rom_idx;

    always_comb begin
        rom_idx = addr[ADDR_W-1:ROM_AW];
        addrb   = addr[ROM_AW-1:0];
        oor     = (32'(rom_idx) >= NUM_ROMS);
        cs      = '0;
        // an out-of-range index matches no ROM, so cs stays all-zero
        for (int unsigned i = 0; i < NUM_ROMS; i++) begin
            cs[i] = (32'(rom_idx) == i);
        end
    end

endmodule

// File: rtl/rom24x8_read_arbiter.sv
// Two-requester read arbiter and sequencer for the 24x8 ROM bank.
// Define ROUND_ROBIN_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module rom24x8_read_arbiter
    import rom24_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int NUM_ROMS  = rom24_pkg::NUM_ROMS,
    parameter int ROM_DEPTH = rom24_pkg::ROM_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0,
    input  logic [ADDR_W-1:0]          addr0,
    output logic                       ack0,
    input  logic                       req1,
    input  logic [ADDR_W-1:0]          addr1,
    output logic                       ack1,
    output logic [DATA_W-1:0]          rdata,
    output logic                       err,
    output logic [NUM_ROMS-1:0]        cs,
    output logic [$clog2(ROM_DEPTH)-1:0] addrb,
    output logic                       read_en,
    input  logic [NUM_ROMS*DATA_W-1:0] datab
);

    localparam int LOC_AW = $clog2(ROM_DEPTH);

    state_t              state;
    logic                gnt_id;
    logic                oor_q;
    logic                pick1;
    logic [ADDR_W-1:0]   sel_addr;
    logic [NUM_ROMS-1:0] dec_cs;
    logic [LOC_AW-1:0]   dec_addrb;
    logic                dec_oor;
    logic [DATA_W-1:0]   rd_mux;

`ifdef ROUND_ROBIN_EN
    logic last_gnt;

    // last_gnt holds the id granted most recently; a tie goes to the other one
    always_comb begin
        pick1 = req1 && (!req0 || !last_gnt);
    end
`else
    always_comb begin
        pick1 = !req0;
    end
`endif

    always_comb begin
        sel_addr = pick1 ? addr1 : addr0;
    end

    rom24_addr_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_ROMS (NUM_ROMS),
        .ROM_AW   (LOC_AW)
    ) u_decode (
        .addr  (sel_addr),
        .cs    (dec_cs),
        .addrb (dec_addrb),
        .oor   (dec_oor)
    );

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_ROMS; i++) begin
            rd_mux = rd_mux | (datab[i*DATA_W +: DATA_W] & {DATA_W{cs[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            cs      <= '0;
            addrb   <= '0;
            read_en <= 1'b0;
            gnt_id  <= 1'b0;
            oor_q   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_id  <= pick1;
                        cs      <= dec_cs;
                        addrb   <= dec_addrb;
                        read_en <= !dec_oor;
                        oor_q   <= dec_oor;
`ifdef ROUND_ROBIN_EN
                        last_gnt <= pick1;
`endif
                        state   <= READ;
                    end
                end
                READ: begin
                    rdata   <= rd_mux;
                    err     <= oor_q;
                    ack0    <= !gnt_id;
                    ack1    <= gnt_id;
                    cs      <= '0;
                    addrb   <= '0;
                    read_en <= 1'b0;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom24x8_read_arbiter.sv
// Scoreboard bench for rom24x8_read_arbiter with a behavioural ROM bank on datab.
module tb_rom24x8_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [4:0]  addr0, addr1;
    logic        ack0, ack1;
    logic [7:0]  rdata;
    logic        err;
    logic [2:0]  cs;
    logic [2:0]  addrb;
    logic        read_en;
    logic [23:0] datab;

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rom24x8_read_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .addr0   (addr0),
        .ack0    (ack0),
        .req1    (req1),
        .addr1   (addr1),
        .ack1    (ack1),
        .rdata   (rdata),
        .err     (err),
        .cs      (cs),
        .addrb   (addrb),
        .read_en (read_en),
        .datab   (datab)
    );

    // ROM contents: word at linear address a is (10*a + 224) mod 256
    function automatic logic [7:0] rom_word(int unsigned a);
        return 8'((a * 10 + 224) & 255);
    endfunction

    always_comb begin
        datab = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            datab[i*8 +: 8] = rom_word(i * 8 + 32'(addrb));
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t expect_for(logic id, int unsigned a);
        exp_t e;
        e.id   = id;
        e.err  = (a >= 24);
        e.data = e.err ? 8'h00 : rom_word(a);
        return e;
    endfunction

    always @(negedge clk) begin
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_id", {30'd0, ack1, ack0}, e.id ? 32'd2 : 32'd1);
                chk("rdata", 32'(rdata), 32'(e.data));
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One read: issued after a posedge while the arbiter is idle
    task automatic do_read(logic id, logic [4:0] a);
        logic [2:0] exp_cs;
        exp_cs = (a >= 24) ? 3'b000 : 3'(1 << (a / 8));
        sb.push_back(expect_for(id, 32'(a)));
        if (id) begin req1 = 1'b1; addr1 = a; end
        else    begin req0 = 1'b1; addr0 = a; end
        step();
        @(negedge clk);
        chk($sformatf("cs_a%0d", a), 32'(cs), 32'(exp_cs));
        chk($sformatf("addrb_a%0d", a), 32'(addrb), 32'(a % 8));
        chk($sformatf("read_en_a%0d", a), 32'(read_en), (a >= 24) ? 32'd0 : 32'd1);
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b0;
        addr0 = 5'd16;
        addr1 = 5'd0;

        // 1. reset held for two cycles with req0 high
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_ack0", 32'(ack0), 32'd0);
            chk("rst_cs", 32'(cs), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
            chk("rst_read_en", 32'(read_en), 32'd0);
        end
        step();
        rst_n = 1'b1;
        sb.push_back(expect_for(1'b0, 16));
        step();
        @(negedge clk);
        chk("first_ack0_early", 32'(ack0), 32'd0);
        chk("first_cs", 32'(cs), 32'd4);
        step();
        @(negedge clk);
        chk("first_ack0_lat2", 32'(ack0), 32'd1);
        req0 = 1'b0;
        step();

        // 2-4. single reads, in-range, top of range, out of range
        do_read(1'b0, 5'd16);
        do_read(1'b1, 5'd23);
        do_read(1'b0, 5'd24);
        do_read(1'b0, 5'd31);
        do_read(1'b1, 5'd0);
        do_read(1'b0, 5'd9);

        // 5. contention from a fresh pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 5'd16;
        addr1 = 5'd17;
        for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
            sb.push_back(expect_for(1'(k % 2), (k % 2) ? 17 : 16));
`else
            sb.push_back(expect_for(1'b0, 16));
`endif
        end
        for (int c = 0; c < 12; c++) step();
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        chk("contention_drained", 32'(sb.size()), 32'd0);

        // 6. reset during READ aborts the access
        req0  = 1'b1;
        addr0 = 5'd17;
        step();
        rst_n = 1'b0;
        req0  = 1'b0;
        @(negedge clk);
        chk("midrst_read_en_pre", 32'(read_en), 32'd1);
        @(negedge clk);
        chk("midrst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("midrst_cs", 32'(cs), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_read_en", 32'(read_en), 32'd0);
        chk("midrst_addrb", 32'(addrb), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        do_read(1'b1, 5'd17);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        chk("timeout", 32'd1, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "FAIL timeout");
    end

endmodule
